// File: rtl/comparator_4bit.sv
// Registered magnitude comparator with selectable signed/unsigned mode and a one-cycle valid pipe.
// Optional |A-B| output port "diff" is built only when COMP_DIFF_EN is defined.
module comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  output logic             out_valid,
  output logic             less,
  output logic             equal,
  output logic             greater
`ifdef COMP_DIFF_EN
  ,
  output logic [WIDTH-1:0] diff
`endif
);

  // ready_q blocks the edge on which reset is released from taking a sample
  logic ready_q, ready_d;
  logic out_valid_q, out_valid_d;
  logic less_q, less_d;
  logic equal_q, equal_d;
  logic greater_q, greater_d;
  logic signed [WIDTH:0] a_ext_s, b_ext_s;
  logic lt_s, eq_s, sample_s;
`ifdef COMP_DIFF_EN
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] mag_s;
`endif

  // Operand compare: one extra bit carries sign-extension in signed mode, zero otherwise
  always_comb begin
    a_ext_s = $signed({is_signed & w0[WIDTH-1], w0});
    b_ext_s = $signed({is_signed & w1[WIDTH-1], w1});
    eq_s    = (w0 == w1);
    lt_s    = (a_ext_s < b_ext_s);
  end

`ifdef COMP_DIFF_EN
  // Magnitude is below 2**WIDTH in both modes, so modulo subtraction is exact
  always_comb begin
    mag_s = {WIDTH{1'b0}};
    if (lt_s) begin
      mag_s = w1 - w0;
    end else begin
      mag_s = w0 - w1;
    end
  end
`endif

  // Next-state: capture on an accepted sample, otherwise hold the last result
  always_comb begin
    sample_s    = in_valid & ready_q;
    ready_d     = 1'b1;
    out_valid_d = sample_s;
    less_d      = less_q;
    equal_d     = equal_q;
    greater_d   = greater_q;
`ifdef COMP_DIFF_EN
    diff_d      = diff_q;
`endif
    if (sample_s) begin
      less_d    = lt_s;
      equal_d   = eq_s;
      greater_d = ~lt_s & ~eq_s;
`ifdef COMP_DIFF_EN
      diff_d    = mag_s;
`endif
    end else begin
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
`ifdef COMP_DIFF_EN
      diff_d    = diff_q;
`endif
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
`ifdef COMP_DIFF_EN
      diff_q      <= {WIDTH{1'b0}};
`endif
    end else begin
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
`ifdef COMP_DIFF_EN
      diff_q      <= diff_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
`ifdef COMP_DIFF_EN
  assign diff      = diff_q;
`endif

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit: directed vector table, reset/hold sequences,
// and randomized traffic against an integer-arithmetic reference model.
module tb_comparator_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       is_signed;
  logic [3:0] w0;
  logic [3:0] w1;
  logic       out_valid;
  logic       less;
  logic       equal;
  logic       greater;
`ifdef COMP_DIFF_EN
  logic [3:0] diff;
`endif

  int checks;
  int failures;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic       lt;
    logic       eq;
    logic       gt;
    logic [3:0] d;
  } vec_t;

  vec_t vecs[12];

  // Held reference result
  logic       m_lt, m_eq, m_gt;
  logic [3:0] m_d;

  comparator_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .is_signed (is_signed),
    .w0        (w0),
    .w1        (w1),
    .out_valid (out_valid),
    .less      (less),
    .equal     (equal),
    .greater   (greater)
`ifdef COMP_DIFF_EN
    ,
    .diff      (diff)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic lt, input logic eq,
                         input logic gt, input logic [3:0] d);
    chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, ov});
    chk({tag, ".less"},      {3'b000, less},      {3'b000, lt});
    chk({tag, ".equal"},     {3'b000, equal},     {3'b000, eq});
    chk({tag, ".greater"},   {3'b000, greater},   {3'b000, gt});
`ifdef COMP_DIFF_EN
    chk({tag, ".diff"}, diff, d);
`else
    if (d !== d) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] a, input logic [3:0] b);
    in_valid  = v;
    is_signed = s;
    w0        = a;
    w1        = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret the operands as integers in the chosen mode and compare
  task automatic ref_cmp(input logic s, input logic [3:0] a, input logic [3:0] b,
                         output logic lt, output logic eq, output logic gt, output logic [3:0] d);
    int ia, ib, df;
    ia = (s && a >= 4'd8) ? int'(a) - 16 : int'(a);
    ib = (s && b >= 4'd8) ? int'(b) - 16 : int'(b);
    lt = (ia < ib);
    eq = (ia == ib);
    gt = (ia > ib);
    df = (ia > ib) ? ia - ib : ib - ia;
    d  = df[3:0];
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //        s     a      b      lt    eq    gt    d
    vecs[0]  = '{1'b0, 4'd1,  4'd1,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 4'd5,  4'd5,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 4'd8,  4'd8,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 4'd10, 4'd10, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 4'd3,  4'd1,  1'b0, 1'b0, 1'b1, 4'd2};
    vecs[5]  = '{1'b0, 4'd6,  4'd11, 1'b1, 1'b0, 1'b0, 4'd5};
    vecs[6]  = '{1'b1, 4'd6,  4'd11, 1'b0, 1'b0, 1'b1, 4'd11};
    vecs[7]  = '{1'b0, 4'd0,  4'd15, 1'b1, 1'b0, 1'b0, 4'd15};
    vecs[8]  = '{1'b1, 4'd7,  4'd8,  1'b0, 1'b0, 1'b1, 4'd15};
    vecs[9]  = '{1'b1, 4'd8,  4'd8,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 4'd8,  4'd7,  1'b1, 1'b0, 1'b0, 4'd15};
    vecs[11] = '{1'b1, 4'd15, 4'd0,  1'b1, 1'b0, 1'b0, 4'd1};

    // Power-on reset: outputs zero before any clock edge
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 4'd1);
    #1;
    chk_all("por", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Release: the first edge after release is ignored even with in_valid high
    rst = 1'b0;
    tick();
    chk_all("rel_edge", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Directed table, back-to-back so out_valid stays high throughout
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].s, vecs[i].a, vecs[i].b);
      tick();
      chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].lt, vecs[i].eq, vecs[i].gt, vecs[i].d);
    end

    // Hold: three idle cycles with changing operands keep the last result
    drive(1'b1, 1'b0, 4'd6, 4'd11);
    tick();
    chk_all("hold_src", 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'(k), 4'(k * 5 + 2), 4'(15 - k));
      tick();
      chk_all($sformatf("hold%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    end

    // Mid-stream reset clears outputs at once and produces no pulse after release
    drive(1'b1, 1'b1, 4'd7, 4'd8);
    tick();
    chk_all("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd15);
    tick();
    chk_all("first_after", 1'b1, 1'b1, 1'b0, 1'b0, 4'd15);

    // Randomized traffic against the reference model
    m_lt = 1'b1; m_eq = 1'b0; m_gt = 1'b0; m_d = 4'd15;
    for (int n = 0; n < 300; n++) begin
      logic v, s, lt, eq, gt;
      logic [3:0] a, b, d;
      v = ($urandom_range(3, 0) != 0);
      s = 1'($urandom_range(1, 0));
      a = 4'($urandom_range(15, 0));
      b = ($urandom_range(7, 0) == 0) ? a : 4'($urandom_range(15, 0));
      drive(v, s, a, b);
      tick();
      if (v) begin
        ref_cmp(s, a, b, lt, eq, gt, d);
        m_lt = lt; m_eq = eq; m_gt = gt; m_d = d;
      end
      chk_all($sformatf("rnd%0d", n), v, m_lt, m_eq, m_gt, m_d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_4bit.md
COMPARATOR_4BIT -- requirements
Module: comparator_4bit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; only the value 4 is required to be supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  high = sample operands this cycle.
REQ-005 is_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-006 w0  input  4  operand A.
REQ-007 w1  input  4  operand B.
REQ-008 out_valid  output  1  high for one cycle when the result registers hold a new result.
REQ-009 less  output  1  registered flag: A < B.
REQ-010 equal  output  1  registered flag: A == B.
REQ-011 greater  output  1  registered flag: A > B.
REQ-012 diff  output  4  registered |A - B|; this port exists only when COMP_DIFF_EN is defined.

Function
REQ-013 On a rising clk with in_valid=1, the module SHALL register less/equal/greater from the w0, w1 and is_signed values present at that edge; latency is 1 cycle.
REQ-014 Exactly one of less/equal/greater SHALL be 1 after any valid sample.
REQ-015 Unsigned mode SHALL treat operands as 0..15; signed mode SHALL treat them as -8..7 (e.g. 4'b1000 = -8).
REQ-016 equal SHALL depend only on bit equality and be independent of is_signed.
REQ-017 With in_valid=0, less/equal/greater (and diff) SHALL hold their last values, and out_valid SHALL be 0 on the next cycle.
REQ-018 out_valid SHALL equal in_valid delayed by one cycle; back-to-back valid samples SHALL each produce one result, with no bubbles.
REQ-019 The extreme cases SHALL compare correctly with no overflow: unsigned 0 vs 15 gives less; signed 7 vs -8 gives greater.

Reset
REQ-020 While rst=1, out_valid, less, equal, greater and diff SHALL be 0 immediately, independent of clk.
REQ-021 A sample presented on the clk edge at which rst deasserts SHALL be ignored; the first result SHALL come from the next valid edge.
REQ-022 Asserting rst mid-stream SHALL discard any pending result; no out_valid pulse SHALL follow the reset.

Configuration
REQ-023 Macro COMP_DIFF_EN:
- Defined: diff port present; diff is registered together with the flags and equals |A-B| in the active mode.
- Signed mode: diff is an unsigned 4-bit magnitude; 7 - (-8) = 15 fits.
- Undefined: diff port and its logic are absent; all other behaviour is identical.

Verification
REQ-024 Reset check: rst=1 mid-operation -> all outputs 0 within the same cycle, no out_valid after release.
REQ-025 Equal cases, unsigned: w0=1,w1=1; w0=5,w1=5; w0=8,w1=8; w0=10,w1=10 -> equal=1, less=0, greater=0, one cycle after each sample.
REQ-026 Greater, unsigned: w0=3, w1=1 -> greater=1, diff=2 (COMP_DIFF_EN defined).
REQ-027 Mode dependence: w0=6, w1=11 with is_signed=0 -> less=1, diff=5; same operands with is_signed=1 (11 = -5) -> greater=1, diff=11.
REQ-028 Hold and handshake: valid sample, then 3 cycles with in_valid=0 and changing operands -> flags unchanged and out_valid=0 in those cycles; back-to-back samples -> out_valid stays 1 continuously.
REQ-029 Extremes: unsigned 0 vs 15 -> less=1, diff=15; signed 7 vs 8 (-8) -> greater=1, diff=15.
